// File: rtl/rr_arbiter_16.sv
// Sixteen-way round-robin arbiter with per-owner hold limit and a one-hot grant
// produced by decoding the registered owner index.

module decoder_4to16 (
    input  logic [3:0]  idx_i,
    output logic [15:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

module rr_arbiter_16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] req_i,
    output logic        gnt_valid_o,
    output logic [3:0]  gnt_idx_o,
    output logic [15:0] gnt_o,
    output logic        hold_expired_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [7:0] HoldLimit = 8'(MAX_HOLD);

    state_e      state_q;
    logic [3:0]  gnt_idx_q;
    logic [3:0]  last_idx_q;
    logic [7:0]  hold_cnt_q;
    logic        gnt_valid_q;
    logic        hold_expired_q;

    logic [3:0]  winner;
    logic [3:0]  cand;
    logic        found;
    logic        owner_req;
    logic        hold_hit;
    logic [15:0] dec_onehot;

    // Search starts just past the last owner, so the last owner is checked last.
    always_comb begin
        winner = last_idx_q;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i <= 16; i++) begin
            cand = last_idx_q + 4'(i);
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign owner_req = req_i[gnt_idx_q];
    assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HoldLimit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            gnt_idx_q      <= 4'd0;
            last_idx_q     <= 4'd15;
            hold_cnt_q     <= 8'd0;
            gnt_valid_q    <= 1'b0;
            hold_expired_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    hold_expired_q <= 1'b0;
                    if (|req_i) begin
                        state_q     <= StGrant;
                        gnt_valid_q <= 1'b1;
                        gnt_idx_q   <= winner;
                        last_idx_q  <= winner;
                        hold_cnt_q  <= 8'd1;
                    end
                end
                StGrant: begin
                    if (!owner_req || hold_hit) begin
                        state_q        <= StIdle;
                        gnt_valid_q    <= 1'b0;
                        gnt_idx_q      <= 4'd0;
                        hold_cnt_q     <= 8'd0;
                        // A release in the limit cycle takes precedence: no pulse.
                        hold_expired_q <= owner_req;
                    end else if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    decoder_4to16 u_dec (
        .idx_i    (gnt_idx_q),
        .onehot_o (dec_onehot)
    );

    assign gnt_valid_o    = gnt_valid_q;
    assign gnt_idx_o      = gnt_idx_q;
    assign gnt_o          = dec_onehot & {16{gnt_valid_q}};
    assign hold_expired_o = hold_expired_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: four instances with different hold limits
// share one clock; outputs are sampled 1 time unit after each rising edge.

module tb_rr_arbiter_16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Instance a: unlimited hold. b: limit 1. c: limit 3. d: limit 2.
    logic        rst_a, rst_b, rst_c, rst_d;
    logic [15:0] req_a, req_b, req_c, req_d;
    logic        vld_a, vld_b, vld_c, vld_d;
    logic [3:0]  idx_a, idx_b, idx_c, idx_d;
    logic [15:0] gnt_a, gnt_b, gnt_c, gnt_d;
    logic        he_a, he_b, he_c, he_d;

    rr_arbiter_16 #(.MAX_HOLD(0)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .req_i(req_a),
        .gnt_valid_o(vld_a), .gnt_idx_o(idx_a), .gnt_o(gnt_a), .hold_expired_o(he_a)
    );
    rr_arbiter_16 #(.MAX_HOLD(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .req_i(req_b),
        .gnt_valid_o(vld_b), .gnt_idx_o(idx_b), .gnt_o(gnt_b), .hold_expired_o(he_b)
    );
    rr_arbiter_16 #(.MAX_HOLD(3)) u_dut_c (
        .clk_i(clk), .rst_i(rst_c), .req_i(req_c),
        .gnt_valid_o(vld_c), .gnt_idx_o(idx_c), .gnt_o(gnt_c), .hold_expired_o(he_c)
    );
    rr_arbiter_16 #(.MAX_HOLD(2)) u_dut_d (
        .clk_i(clk), .rst_i(rst_d), .req_i(req_d),
        .gnt_valid_o(vld_d), .gnt_idx_o(idx_d), .gnt_o(gnt_d), .hold_expired_o(he_d)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic vld, input logic [3:0] idx,
                         input logic [15:0] g, input logic he, input logic e_vld,
                         input logic [3:0] e_idx, input logic [15:0] e_g, input logic e_he);
        logic [21:0] obs;
        logic [21:0] exp;
        obs = {vld, idx, g, he};
        exp = {e_vld, e_idx, e_g, e_he};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed vld=%0b idx=%0d gnt=%h he=%0b, expected vld=%0b idx=%0d gnt=%h he=%0b",
                   tag, vld, idx, g, he, e_vld, e_idx, e_g, e_he);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [3:0] i, input logic [15:0] g,
                         input logic e);
        check(tag, vld_a, idx_a, gnt_a, he_a, v, i, g, e);
    endtask
    task automatic chk_b(input string tag, input logic v, input logic [3:0] i, input logic [15:0] g,
                         input logic e);
        check(tag, vld_b, idx_b, gnt_b, he_b, v, i, g, e);
    endtask
    task automatic chk_c(input string tag, input logic v, input logic [3:0] i, input logic [15:0] g,
                         input logic e);
        check(tag, vld_c, idx_c, gnt_c, he_c, v, i, g, e);
    endtask
    task automatic chk_d(input string tag, input logic v, input logic [3:0] i, input logic [15:0] g,
                         input logic e);
        check(tag, vld_d, idx_d, gnt_d, he_d, v, i, g, e);
    endtask

    initial begin
        logic [15:0] onehot;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        req_a = '0;   req_b = '0;   req_c = '0;   req_d = '0;
        step();
        step();
        chk_a("reset_a", 1'b0, 4'd0, 16'h0000, 1'b0);
        chk_b("reset_b", 1'b0, 4'd0, 16'h0000, 1'b0);
        chk_c("reset_c", 1'b0, 4'd0, 16'h0000, 1'b0);
        chk_d("reset_d", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

        // Basic grant and handover with an idle bubble (unlimited hold).
        req_a = 16'h0011;
        step(); chk_a("basic_g0_c1", 1'b1, 4'd0, 16'h0001, 1'b0);
        step(); chk_a("basic_g0_c2", 1'b1, 4'd0, 16'h0001, 1'b0);
        step(); chk_a("basic_g0_c3", 1'b1, 4'd0, 16'h0001, 1'b0);
        req_a = 16'h0010;
        step(); chk_a("basic_bubble", 1'b0, 4'd0, 16'h0000, 1'b0);
        step(); chk_a("basic_g4", 1'b1, 4'd4, 16'h0010, 1'b0);
        req_a = 16'h0000;
        step(); chk_a("basic_idle", 1'b0, 4'd0, 16'h0000, 1'b0);
        step(); chk_a("basic_stay_idle", 1'b0, 4'd0, 16'h0000, 1'b0);

        // Fairness wrap with limit 1: 0..15 then 0, each followed by an expiry cycle.
        req_b = 16'hFFFF;
        for (int k = 0; k <= 16; k++) begin
            onehot = 16'h0001 << (k % 16);
            step(); chk_b($sformatf("wrap_on%0d", k), 1'b1, 4'(k % 16), onehot, 1'b0);
            step(); chk_b($sformatf("wrap_off%0d", k), 1'b0, 4'd0, 16'h0000, 1'b1);
        end
        req_b = 16'h0000;

        // Hold limit 3 with a single persistent requester.
        req_c = 16'h0080;
        step(); chk_c("hold_c1", 1'b1, 4'd7, 16'h0080, 1'b0);
        step(); chk_c("hold_c2", 1'b1, 4'd7, 16'h0080, 1'b0);
        step(); chk_c("hold_c3", 1'b1, 4'd7, 16'h0080, 1'b0);
        step(); chk_c("hold_expire", 1'b0, 4'd0, 16'h0000, 1'b1);
        step(); chk_c("hold_regrant", 1'b1, 4'd7, 16'h0080, 1'b0);
        step(); chk_c("hold_regrant_c2", 1'b1, 4'd7, 16'h0080, 1'b0);
        req_c = 16'h0000;

        // Release in the limit cycle wins over expiry.
        req_d = 16'h0008;
        step(); chk_d("coinc_c1", 1'b1, 4'd3, 16'h0008, 1'b0);
        step(); chk_d("coinc_c2", 1'b1, 4'd3, 16'h0008, 1'b0);
        req_d = 16'h0000;
        step(); chk_d("coinc_release", 1'b0, 4'd0, 16'h0000, 1'b0);
        step(); chk_d("coinc_idle", 1'b0, 4'd0, 16'h0000, 1'b0);

        // Mid-grant reset: pointer returns to 15, so lowest set index wins.
        req_a = 16'h0200;
        step(); chk_a("mrst_g9", 1'b1, 4'd9, 16'h0200, 1'b0);
        rst_a = 1'b1;
        req_a = 16'h0600;
        step(); chk_a("mrst_reset", 1'b0, 4'd0, 16'h0000, 1'b0);
        rst_a = 1'b0;
        step(); chk_a("mrst_after", 1'b1, 4'd9, 16'h0200, 1'b0);
        req_a = 16'h0000;
        step(); chk_a("mrst_idle", 1'b0, 4'd0, 16'h0000, 1'b0);

        // Late requester: ignored during grant, served after release.
        req_a = 16'h0004;
        step(); chk_a("late_g2", 1'b1, 4'd2, 16'h0004, 1'b0);
        req_a = 16'h0006;
        step(); chk_a("late_hold1", 1'b1, 4'd2, 16'h0004, 1'b0);
        step(); chk_a("late_hold2", 1'b1, 4'd2, 16'h0004, 1'b0);
        req_a = 16'h0002;
        step(); chk_a("late_bubble", 1'b0, 4'd0, 16'h0000, 1'b0);
        step(); chk_a("late_g1", 1'b1, 4'd1, 16'h0002, 1'b0);
        req_a = 16'h0000;
        step(); chk_a("late_idle", 1'b0, 4'd0, 16'h0000, 1'b0);

        // Late requester 1 loses to index 13, which lies between 2 and the wrap.
        req_a = 16'h0004;
        step(); chk_a("late2_g2", 1'b1, 4'd2, 16'h0004, 1'b0);
        req_a = 16'h2006;
        step(); chk_a("late2_hold", 1'b1, 4'd2, 16'h0004, 1'b0);
        req_a = 16'h2002;
        step(); chk_a("late2_bubble", 1'b0, 4'd0, 16'h0000, 1'b0);
        step(); chk_a("late2_g13", 1'b1, 4'd13, 16'h2000, 1'b0);
        req_a = 16'h0002;
        step(); chk_a("late2_bubble2", 1'b0, 4'd0, 16'h0000, 1'b0);
        step(); chk_a("late2_g1", 1'b1, 4'd1, 16'h0002, 1'b0);
        req_a = 16'h0000;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
